alarm_siren_ctrl: RTL and testbench
===================================

Name: alarm_siren_ctrl

Overview:
Downstream consumer of the fire alarm's alarmEnable output. It confirms the alarm request and then latches it. While latched it drives a pulsed siren and a strobe, and it supports a user acknowledge (hush) with a timed re-arm. A saturating event counter is kept for the panel display.

Parameters:
CONFIRM_CYCLES, 4, number of further consecutive high samples of alarmEnable required after the first high sample before the alarm latches (minimum 1)
BEEP_HALF, 8, siren on-time and off-time in clocks (minimum 1)
HUSH_CYCLES, 64, duration of the hush period in clocks (minimum 1)

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst  input  1  synchronous, active-high reset
alarmEnable  input  1  smoke alarm request from the fire alarm stage; level signal
ack  input  1  user acknowledge/hush; single-cycle pulse, sampled every clock
siren  output  1  buzzer drive; pulsed pattern
strobe  output  1  visual indicator
alarm_active  output  1  high while the alarm is latched (ALARM or HUSH)
state  output  3  current FSM state encoding, for debug and the panel
event_count  output  8  number of confirmed alarm events; saturates at 255

Behaviour:
- Reset: rst is synchronous and active-high on clk. When rst=1 at a rising edge:
  - FSM goes to IDLE.
  - siren, strobe and alarm_active are 0; state is 0; event_count is 0.
  - All internal counters are cleared.
  - Reset has priority over every input and applies in any state, including mid-beep and mid-hush.
- All outputs are registered. There is no combinational path from an input to an output.
- State encoding: IDLE=0, CONFIRM=1, ALARM=2, HUSH=3, TEST=4 (TEST exists only with the optional feature).
- IDLE:
  - Outputs 0.
  - alarmEnable=1 -> CONFIRM, with the confirm counter set to 0.
  - ack is ignored.
- CONFIRM:
  - Outputs 0.
  - alarmEnable=0 -> IDLE.
  - alarmEnable=1 and confirm counter equal to CONFIRM_CYCLES-1 -> ALARM; otherwise the counter increments.
  - Net effect: ALARM is entered at the edge where alarmEnable has been sampled high CONFIRM_CYCLES+1 consecutive times.
  - ack is ignored.
- Entry to ALARM from CONFIRM increments event_count, holding at 255 once saturated.
- ALARM:
  - alarm_active=1 and strobe=1.
  - siren is high for the first BEEP_HALF cycles after entry, then low for BEEP_HALF, and repeats. The beep counter restarts on every entry to ALARM.
  - The alarm is latched: alarmEnable falling does not leave ALARM.
  - ack=1 with alarmEnable=0 -> IDLE.
  - ack=1 with alarmEnable=1 -> HUSH, with the hush counter set to 0.
- HUSH:
  - siren=0, strobe=1, alarm_active=1.
  - The hush counter increments every cycle; ack is ignored.
  - When the hush counter equals HUSH_CYCLES-1:
    - alarmEnable=1 -> ALARM. This re-entry restarts the beep pattern with siren high and does not increment event_count.
    - alarmEnable=0 -> IDLE.
- A state change takes effect at the edge; the outputs reflect the new state in the same cycle the state output does.
- Counter widths are sized with $clog2 of the respective parameter. No counter exceeds its parameter, and no wrap occurs.

Optional Feature:
ALARM_SELFTEST_EN
- When defined:
  - Adds input port self_test (1 bit).
  - In IDLE, self_test=1 -> TEST.
  - TEST lasts 2*BEEP_HALF cycles: siren is high for the first BEEP_HALF cycles and low for the second; strobe=1; alarm_active=0.
  - At the end of TEST, the FSM returns to IDLE.
  - alarmEnable=1 during TEST aborts immediately to CONFIRM with the counter set to 0.
  - event_count is unchanged by TEST.
  - self_test in any state other than IDLE is ignored.
- When not defined: the self_test port is absent, TEST is unreachable, and behaviour is exactly as above.

Test Plan:
1. Confirm path, defaults: rst for 2 cycles, then alarmEnable=1 held.
   -> alarm_active=1 and state=2 after the 5th rising edge with alarmEnable high.
   -> siren=1 for 8 cycles, then 0 for 8 cycles.
   -> event_count=1.
2. Glitch rejection: alarmEnable=1 for 3 edges, then 0.
   -> State returns to 0; alarm_active is never 1; event_count stays 0.
3. Hush and re-arm: latched alarm with alarmEnable=1, pulse ack.
   -> state=3 and siren=0 for 64 cycles, then state=2 with siren=1.
   -> event_count is unchanged.
4. Clear: in ALARM, drop alarmEnable; siren keeps pulsing; then pulse ack.
   -> state=0 and all outputs 0 on the next cycle.
5. Saturation and reset: drive 256 confirm/clear cycles.
   -> event_count holds at 255.
   Assert rst mid-beep.
   -> Next cycle: siren=0, state=0, event_count=0.
6. With ALARM_SELFTEST_EN defined: pulse self_test in IDLE.
   -> siren high 8 cycles, low 8 cycles; alarm_active stays 0; then state=0.
   Repeat with alarmEnable=1 at cycle 3 of TEST.
   -> state=1.

Source files
------------

// File: rtl/alarm_siren_ctrl.sv
// ============================================================================
// alarm_siren_ctrl : confirms and latches the smoke alarm request, drives
// pulsed siren/strobe, supports hush with timed re-arm, counts alarm events.
// Optional self-test mode: `define ALARM_SELFTEST_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

module alarm_siren_ctrl #(
  parameter int CONFIRM_CYCLES = 4,
  parameter int BEEP_HALF      = 8,
  parameter int HUSH_CYCLES    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alarmEnable,
  input  logic       ack,
`ifdef ALARM_SELFTEST_EN
  input  logic       self_test,
`endif
  output logic       siren,
  output logic       strobe,
  output logic       alarm_active,
  output logic [2:0] state,
  output logic [7:0] event_count
);

  localparam int CONF_W = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;
  localparam int BEEP_W = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
  localparam int HUSH_W = (HUSH_CYCLES > 1) ? $clog2(HUSH_CYCLES) : 1;

  localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONFIRM_CYCLES - 1);
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_HALF - 1);
  localparam logic [HUSH_W-1:0] HUSH_LAST = HUSH_W'(HUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONFIRM = 3'd1,
    S_ALARM   = 3'd2,
    S_HUSH    = 3'd3,
    S_TEST    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CONF_W-1:0] conf_q, conf_d;
  logic [BEEP_W-1:0] beep_q, beep_d;
  logic [HUSH_W-1:0] hush_q, hush_d;
  logic [7:0]        ev_q, ev_d;
  logic              siren_q, siren_d;
  logic              strobe_q, strobe_d;
  logic              active_q, active_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      conf_q   <= '0;
      beep_q   <= '0;
      hush_q   <= '0;
      ev_q     <= '0;
      siren_q  <= 1'b0;
      strobe_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      conf_q   <= conf_d;
      beep_q   <= beep_d;
      hush_q   <= hush_d;
      ev_q     <= ev_d;
      siren_q  <= siren_d;
      strobe_q <= strobe_d;
      active_q <= active_d;
    end
  end

  // Outputs are computed from the next state so they change on the same edge as state.
  always_comb begin
    state_d  = state_q;
    conf_d   = conf_q;
    beep_d   = beep_q;
    hush_d   = hush_q;
    ev_d     = ev_q;
    siren_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (alarmEnable) begin
          state_d = S_CONFIRM;
          conf_d  = '0;
        end
`ifdef ALARM_SELFTEST_EN
        else if (self_test) begin
          state_d = S_TEST;
          beep_d  = '0;
          siren_d = 1'b1;
        end
`endif
      end
      S_CONFIRM: begin
        if (!alarmEnable) begin
          state_d = S_IDLE;
        end else if (conf_q == CONF_LAST) begin
          state_d = S_ALARM;
          beep_d  = '0;
          siren_d = 1'b1;
          ev_d    = (ev_q == 8'hFF) ? ev_q : ev_q + 8'd1;
        end else begin
          conf_d = conf_q + CONF_W'(1);
        end
      end
      S_ALARM: begin
        if (ack) begin
          if (alarmEnable) begin
            state_d = S_HUSH;
            hush_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (beep_q == BEEP_LAST) begin
          beep_d  = '0;
          siren_d = ~siren_q;
        end else begin
          beep_d  = beep_q + BEEP_W'(1);
          siren_d = siren_q;
        end
      end
      S_HUSH: begin
        if (hush_q == HUSH_LAST) begin
          if (alarmEnable) begin
            state_d = S_ALARM;
            beep_d  = '0;
            siren_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          hush_d = hush_q + HUSH_W'(1);
        end
      end
`ifdef ALARM_SELFTEST_EN
      S_TEST: begin
        if (alarmEnable) begin
          state_d = S_CONFIRM;
          conf_d  = '0;
        end else if (beep_q == BEEP_LAST) begin
          // Second half complete ends the test; first half flips to the silent half.
          if (!siren_q) begin
            state_d = S_IDLE;
          end else begin
            beep_d  = '0;
            siren_d = 1'b0;
          end
        end else begin
          beep_d  = beep_q + BEEP_W'(1);
          siren_d = siren_q;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    strobe_d = (state_d == S_ALARM) || (state_d == S_HUSH) || (state_d == S_TEST);
    active_d = (state_d == S_ALARM) || (state_d == S_HUSH);
  end

  assign siren        = siren_q;
  assign strobe       = strobe_q;
  assign alarm_active = active_q;
  assign state        = state_q;
  assign event_count  = ev_q;

endmodule

`default_nettype wire

// File: tb/tb_alarm_siren_ctrl.sv
// ============================================================================
// tb_alarm_siren_ctrl : directed scoreboard bench for alarm_siren_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alarm_siren_ctrl;

  logic       clk;
  logic       rst;
  logic       alarmEnable;
  logic       ack;
  logic       self_test;
  logic       siren;
  logic       strobe;
  logic       alarm_active;
  logic [2:0] state;
  logic [7:0] event_count;

  int errors;
  int checks;
  logic [7:0] exp_cnt;

  typedef struct {
    logic [2:0] st;
    logic       sr;
    logic       sb;
    logic       aa;
    logic [7:0] ec;
  } exp_t;

  exp_t sb_q[$];

  alarm_siren_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .alarmEnable  (alarmEnable),
    .ack          (ack),
`ifdef ALARM_SELFTEST_EN
    .self_test    (self_test),
`endif
    .siren        (siren),
    .strobe       (strobe),
    .alarm_active (alarm_active),
    .state        (state),
    .event_count  (event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, record the expected post-edge outputs, then compare.
  task automatic cyc(input logic ae, input logic ak, input logic [2:0] st, input logic sr,
                     input logic sb, input logic aa, input logic [7:0] ec, input string tag);
    exp_t e;
    alarmEnable = ae;
    ack         = ak;
    sb_q.push_back('{st: st, sr: sr, sb: sb, aa: aa, ec: ec});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    assert (state === e.st) else begin
      errors++;
      $error("FAIL %s state: observed %0d expected %0d", tag, state, e.st);
    end
    check_bit({tag, " siren"}, siren, e.sr);
    check_bit({tag, " strobe"}, strobe, e.sb);
    check_bit({tag, " alarm_active"}, alarm_active, e.aa);
    checks++;
    assert (event_count === e.ec) else begin
      errors++;
      $error("FAIL %s event_count: observed %0d expected %0d", tag, event_count, e.ec);
    end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst         = 1'b1;
    alarmEnable = 1'b0;
    ack         = 1'b0;
    self_test   = 1'b0;
    exp_cnt     = 8'd0;

    cyc(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, "reset0");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, "reset1");
    rst = 1'b0;

    // Glitch rejection: three high samples then low
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0, "glitch_confirm");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, "glitch_idle");
    cyc(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, "idle_ack_ignored");

    // Confirm path: latch on the 5th high edge
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0, "confirm");
    cyc(1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 8'd1, "alarm_entry");
    for (int i = 1; i < 8; i++) cyc(1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 8'd1, "beep_on");
    for (int i = 8; i < 16; i++) cyc(1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b1, 8'd1, "beep_off");
    cyc(1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 8'd1, "beep_on_again");

    // Hush and re-arm
    cyc(1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 8'd1, "hush_entry");
    for (int i = 1; i < 64; i++)
      cyc(1'b1, (i == 10), 3'd3, 1'b0, 1'b1, 1'b1, 8'd1, "hush");
    cyc(1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 8'd1, "rearm");

    // Clear: alarm stays latched with alarmEnable low until ack
    for (int i = 1; i < 8; i++) cyc(1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 8'd1, "latched_on");
    for (int i = 8; i < 11; i++) cyc(1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b1, 8'd1, "latched_off");
    cyc(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'd1, "clear");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd1, "clear_hold");

    // Saturation: 256 confirm/clear rounds
    exp_cnt = 8'd1;
    for (int k = 0; k < 256; k++) begin
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, event_count, "sat_confirm");
      cyc(1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, exp_cnt, "sat_alarm");
      cyc(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, exp_cnt, "sat_clear");
    end
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd255, "saturated");

    // Reset mid-beep
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 8'd255, "pre_rst_confirm");
    cyc(1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 8'd255, "pre_rst_alarm");
    cyc(1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 8'd255, "pre_rst_beep");
    rst = 1'b1;
    cyc(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, "rst_mid_beep");
    rst = 1'b0;
    cyc(1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0, "post_rst_confirm");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, "post_rst_idle");

`ifdef ALARM_SELFTEST_EN
    self_test = 1'b1;
    cyc(1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 8'd0, "test_entry");
    self_test = 1'b0;
    for (int i = 1; i < 8; i++) cyc(1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 8'd0, "test_on");
    for (int i = 8; i < 16; i++) cyc(1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 8'd0, "test_off");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, "test_done");

    self_test = 1'b1;
    cyc(1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 8'd0, "test2_entry");
    self_test = 1'b0;
    cyc(1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 8'd0, "test2_c2");
    cyc(1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0, "test2_abort");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, "test2_idle");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
